// File: rtl/lomo_frame_rx_if.sv
// rtl/lomo_frame_rx_if.sv - LOMO line triplet and received-word bus for lomo_frame_rx
interface lomo_frame_rx_if;
   logic        mk_in;
   logic        clk_in;
   logic        dat_in;
   logic [15:0] word_data;
   logic [4:0]  word_idx;
   logic        word_valid;
   logic [8:0]  frm_num;
   logic [5:0]  str_num;
   logic        str_done;
   logic        locked;
   logic        err_hdr;
   logic        err_seq;
   logic        err_align;
   logic        err_static;
   logic [15:0] err_cnt;

   modport slave (
      input  mk_in, clk_in, dat_in,
      output word_data, word_idx, word_valid, frm_num, str_num, str_done,
      output locked, err_hdr, err_seq, err_align, err_static, err_cnt
   );

   modport master (
      output mk_in, clk_in, dat_in,
      input  word_data, word_idx, word_valid, frm_num, str_num, str_done,
      input  locked, err_hdr, err_seq, err_align, err_static, err_cnt
   );
endinterface

// File: rtl/lomo_frame_rx.sv
// rtl/lomo_frame_rx.sv - LOMO MK/CLK/DAT string receiver with header, numbering and alignment checks
// Optional static-field comparator: LOMO_RX_STATIC_CHECK_EN
module lomo_frame_rx #(
   parameter int WORDS_PER_STR = 20,
   parameter int SYNC_STAGES   = 2,
   parameter int TIMEOUT_CYC   = 1024
) (
   input  logic           clk,
   input  logic           reset,
   lomo_frame_rx_if.slave bus
);
   localparam int HALF = WORDS_PER_STR / 2;
   localparam int TW   = $clog2(TIMEOUT_CYC);

   typedef enum logic [1:0] {HUNT, RECV, WAITMK} state_t;

   logic [SYNC_STAGES-1:0] mk_s, clk_s, dat_s;
   logic                   clk_d;
   logic                   line_edge, bit_v, bit_mk;

   state_t      state;
   logic [14:0] sr;
   logic [3:0]  bit_cnt;
   logic [4:0]  cur_idx;
   logic [15:0] hdr0;
   logic        have_prev, str_err;
   logic [1:0]  clean;
   logic [TW-1:0] tmr;

   logic [15:0] word_full;
   logic        hdr_bad, seq_bad;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mk_s  <= '0;
         clk_s <= '0;
         dat_s <= '0;
         clk_d <= 1'b0;
      end else begin
         mk_s  <= {mk_s[SYNC_STAGES-2:0], bus.mk_in};
         clk_s <= {clk_s[SYNC_STAGES-2:0], bus.clk_in};
         dat_s <= {dat_s[SYNC_STAGES-2:0], bus.dat_in};
         clk_d <= clk_s[SYNC_STAGES-1];
      end
   end

   assign line_edge = clk_s[SYNC_STAGES-1] & ~clk_d;
   assign bit_v     = dat_s[SYNC_STAGES-1];
   assign bit_mk    = mk_s[SYNC_STAGES-1];

`ifdef LOMO_RX_STATIC_CHECK_EN
   function automatic logic [11:0] static_ref(input logic [4:0] idx);
      logic [4:0] k;
      k = (idx < 5'(HALF)) ? idx - 5'd1 : idx - 5'(HALF + 1);
      case (k)
         5'd0:    return 12'd1101;
         5'd1:    return 12'd1202;
         5'd2:    return 12'd1303;
         5'd3:    return 12'd0;
         5'd4:    return 12'd240;
         5'd5:    return 12'd3855;
         5'd6:    return 12'd1365;
         5'd7:    return 12'd2730;
         default: return 12'd4095;
      endcase
   endfunction
`endif

   // Frame number may stay or step by one; string number must step by one.
   always_comb begin
      word_full = {sr, bit_v};
      hdr_bad   = !(hdr0[0] && !word_full[0] && (word_full[15:1] == hdr0[15:1]));
      seq_bad   = have_prev &&
                  !((word_full[6:1] == bus.str_num + 6'd1) &&
                    ((word_full[15:7] == bus.frm_num) || (word_full[15:7] == bus.frm_num + 9'd1)));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= HUNT;
         sr             <= '0;
         bit_cnt        <= '0;
         cur_idx        <= '0;
         hdr0           <= '0;
         have_prev      <= 1'b0;
         str_err        <= 1'b0;
         clean          <= '0;
         tmr            <= '0;
         bus.word_data  <= '0;
         bus.word_idx   <= '0;
         bus.word_valid <= 1'b0;
         bus.frm_num    <= '0;
         bus.str_num    <= '0;
         bus.str_done   <= 1'b0;
         bus.locked     <= 1'b0;
         bus.err_hdr    <= 1'b0;
         bus.err_seq    <= 1'b0;
         bus.err_align  <= 1'b0;
         bus.err_static <= 1'b0;
         bus.err_cnt    <= '0;
      end else begin
         bus.word_valid <= 1'b0;
         bus.str_done   <= 1'b0;
         bus.err_hdr    <= 1'b0;
         bus.err_seq    <= 1'b0;
         bus.err_align  <= 1'b0;
         bus.err_static <= 1'b0;

         if ((bus.err_hdr | bus.err_seq | bus.err_align | bus.err_static) && (bus.err_cnt != 16'hFFFF))
            bus.err_cnt <= bus.err_cnt + 16'd1;

         if (line_edge) begin
            tmr <= '0;
         end else if (state != HUNT) begin
            if (tmr == TW'(TIMEOUT_CYC - 1)) begin
               tmr           <= '0;
               state         <= HUNT;
               bus.err_align <= 1'b1;
               bus.locked    <= 1'b0;
               clean         <= '0;
               have_prev     <= 1'b0;
            end else begin
               tmr <= tmr + 1'b1;
            end
         end

         // A marker-bearing bit always becomes bit 15 of a fresh word 0.
         if (line_edge) begin
            if (bit_mk || state == RECV) begin
               if (bit_mk) begin
                  if (state == RECV) begin
                     bus.err_align <= 1'b1;
                     bus.locked    <= 1'b0;
                     clean         <= '0;
                     have_prev     <= 1'b0;
                  end
                  sr      <= {14'd0, bit_v};
                  bit_cnt <= 4'd1;
                  cur_idx <= '0;
                  str_err <= 1'b0;
                  state   <= RECV;
               end else if (bit_cnt != 4'd15) begin
                  sr      <= word_full[14:0];
                  bit_cnt <= bit_cnt + 4'd1;
               end else begin
                  bit_cnt        <= '0;
                  bus.word_valid <= 1'b1;
                  bus.word_data  <= word_full;
                  bus.word_idx   <= cur_idx;
                  if (cur_idx == 5'd0) begin
                     hdr0        <= word_full;
                     bus.frm_num <= word_full[15:7];
                     bus.str_num <= word_full[6:1];
                     if (seq_bad) begin
                        bus.err_seq <= 1'b1;
                        bus.locked  <= 1'b0;
                        clean       <= '0;
                        str_err     <= 1'b1;
                     end
                  end
                  if (cur_idx == 5'(HALF) && hdr_bad) begin
                     bus.err_hdr <= 1'b1;
                     bus.locked  <= 1'b0;
                     clean       <= '0;
                     str_err     <= 1'b1;
                  end
`ifdef LOMO_RX_STATIC_CHECK_EN
                  if (cur_idx != 5'd0 && cur_idx != 5'(HALF) && word_full[15:4] != static_ref(cur_idx))
                     bus.err_static <= 1'b1;
`endif
                  if (cur_idx == 5'(WORDS_PER_STR - 1)) begin
                     bus.str_done <= 1'b1;
                     state        <= WAITMK;
                     cur_idx      <= '0;
                     have_prev    <= 1'b1;
                     if (!str_err) begin
                        clean <= (clean == 2'd0) ? 2'd1 : 2'd2;
                        if (clean != 2'd0)
                           bus.locked <= 1'b1;
                     end
                  end else begin
                     cur_idx <= cur_idx + 5'd1;
                  end
               end
            end else if (state == WAITMK) begin
               bus.err_align <= 1'b1;
               bus.locked    <= 1'b0;
               clean         <= '0;
               have_prev     <= 1'b0;
               state         <= HUNT;
            end
         end
      end
   end
endmodule

// File: tb/tb_lomo_frame_rx.sv
// tb/tb_lomo_frame_rx.sv - randomized string-level bench for lomo_frame_rx against a word scoreboard
module tb_lomo_frame_rx;
   localparam int TO = 1024;
   localparam int SS = 2;
`ifdef LOMO_RX_STATIC_CHECK_EN
   localparam bit STATIC_EN = 1'b1;
`else
   localparam bit STATIC_EN = 1'b0;
`endif

   typedef struct {
      logic [15:0] data;
      logic [4:0]  idx;
      logic        done, hdr, seq, stat;
   } rec_t;

   logic clk = 1'b0;
   logic reset = 1'b0;

   lomo_frame_rx_if bus();

   lomo_frame_rx #(.WORDS_PER_STR(20), .SYNC_STAGES(SS), .TIMEOUT_CYC(TO)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   rec_t q[$];
   int wv_seen, hdr_seen, seq_seen, stat_seen, align_seen;
   int unexp = 0;
   int stray = 0;
   int tbl [9] = '{1101, 1202, 1303, 0, 240, 3855, 1365, 2730, 4095};
   logic [15:0] sw [20];
   bit m_have_prev, m_locked;
   int m_pf, m_ps, m_clean, m_errs, m_aligns;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      rec_t r;
      if (reset) begin
         if (bus.err_hdr)    hdr_seen++;
         if (bus.err_seq)    seq_seen++;
         if (bus.err_static) stat_seen++;
         if (bus.err_align)  align_seen++;
         if (bus.word_valid) begin
            wv_seen++;
            if (q.size() == 0) unexp++;
            else begin
               r = q.pop_front();
               chk("word_data", bus.word_data, r.data);
               chk("word_idx", bus.word_idx, r.idx);
               chk("str_done", bus.str_done, r.done);
               chk("err_hdr", bus.err_hdr, r.hdr);
               chk("err_seq", bus.err_seq, r.seq);
               chk("err_static", bus.err_static, r.stat);
            end
         end else if (bus.str_done | bus.err_hdr | bus.err_seq | bus.err_static) begin
            stray++;
         end
      end
   end

   function automatic bit stat_exp(input int i);
      int k;
      if (i == 0 || i == 10) return 1'b0;
      k = (i < 10) ? i - 1 : i - 11;
      return sw[i][15:4] != 12'(tbl[k]);
   endfunction

   task automatic build(input logic [8:0] f, input logic [5:0] s, input bit hinj, input bit sbad);
      int k;
      for (int i = 0; i < 20; i++) begin
         k = (i < 10) ? i - 1 : i - 11;
         if (i != 0 && i != 10) sw[i] = {12'(tbl[k]), 4'($urandom_range(0, 15))};
      end
      sw[0]  = {f, s, 1'b1};
      sw[10] = {f, s, 1'b0};
      if (hinj) begin
         case ($urandom_range(0, 2))
            0: sw[0][0] = 1'b0;
            1: sw[10][0] = 1'b1;
            default: sw[10][$urandom_range(1, 15)] ^= 1'b1;
         endcase
      end
      if (sbad) begin
         k = $urandom_range(1, 18);
         if (k >= 10) k++;
         sw[k][15:4] = sw[k][15:4] ^ 12'd1;
      end
   endtask

   task automatic model_string(input int nw);
      rec_t r;
      bit bad;
      int f, s;
      bad = 1'b0;
      for (int i = 0; i < nw; i++) begin
         r.data = sw[i];
         r.idx  = 5'(i);
         r.done = (i == 19);
         r.hdr  = 1'b0;
         r.seq  = 1'b0;
         if (i == 0) begin
            f = int'(sw[0][15:7]);
            s = int'(sw[0][6:1]);
            r.seq = m_have_prev && !(s == (m_ps + 1) % 64 && (f == m_pf || f == (m_pf + 1) % 512));
            m_pf = f;
            m_ps = s;
         end
         if (i == 10)
            r.hdr = !(sw[0][0] == 1'b1 && sw[10][0] == 1'b0 && sw[10][15:1] == sw[0][15:1]);
         r.stat = STATIC_EN && stat_exp(i);
         if (r.hdr || r.seq) begin
            m_errs++;
            m_clean  = 0;
            m_locked = 1'b0;
            bad      = 1'b1;
         end
         if (r.stat) m_errs++;
         if (i == 19) begin
            m_have_prev = 1'b1;
            if (!bad) begin
               m_clean  = (m_clean >= 2) ? 2 : m_clean + 1;
               m_locked = (m_clean == 2);
            end
         end
         q.push_back(r);
      end
   endtask

   task automatic model_fault();
      m_errs++;
      m_aligns++;
      m_clean     = 0;
      m_locked    = 1'b0;
      m_have_prev = 1'b0;
   endtask

   task automatic send_bit(input logic b, input logic m);
      @(negedge clk);
      bus.dat_in = b;
      bus.mk_in  = m;
      bus.clk_in = 1'b0;
      @(negedge clk);
      bus.clk_in = 1'b1;
   endtask

   task automatic send_word(input logic [15:0] w, input bit first);
      for (int b = 15; b >= 0; b--) send_bit(w[b], first && b == 15);
   endtask

   task automatic send_string(input int nw, input int nb);
      for (int w = 0; w < nw; w++) send_word(sw[w], w == 0);
      if (nw < 20)
         for (int b = 0; b < nb; b++) send_bit(sw[nw][15-b], 1'b0);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("drain", q.size(), 0);
   endtask

   task automatic check_state();
      chk("locked", bus.locked, m_locked);
      chk("frm_num", bus.frm_num, m_pf);
      chk("str_num", bus.str_num, m_ps);
      chk("err_cnt", bus.err_cnt, m_errs);
   endtask

   task automatic run_string(input logic [8:0] f, input logic [5:0] s, input bit hinj, input bit sbad,
                             input int aw, input int ab);
      build(f, s, hinj, sbad);
      if (aw > 0) begin
         model_string(aw);
         model_fault();
         send_string(aw, ab);
      end else begin
         model_string(20);
         send_string(20, 0);
         wait_drain();
         check_state();
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      bus.mk_in = 1'b0;
      bus.clk_in = 1'b0;
      bus.dat_in = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_word_data", bus.word_data, 0);
      chk("rst_word_idx", bus.word_idx, 0);
      chk("rst_word_valid", bus.word_valid, 0);
      chk("rst_locked", bus.locked, 0);
      chk("rst_err_cnt", bus.err_cnt, 0);
      chk("rst_frm_str", {bus.frm_num, bus.str_num}, 0);
      q.delete();
      {wv_seen, hdr_seen, seq_seen, stat_seen, align_seen} = '0;
      m_have_prev = 1'b0;
      m_locked = 1'b0;
      {m_pf, m_ps, m_clean, m_errs, m_aligns} = '0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int n;
      do_reset();

      run_string(9'd0, 6'd0, 1'b0, 1'b0, 0, 0);
      run_string(9'd0, 6'd1, 1'b0, 1'b0, 0, 0);
      chk("t1_words", wv_seen, 40);
      chk("t1_locked", bus.locked, 1);

      do_reset();
      build(9'd0, 6'd0, 1'b0, 1'b0);
      sw[10] = 16'h0001;
      model_string(20);
      send_string(20, 0);
      wait_drain();
      check_state();
      chk("t3_hdr", hdr_seen, 1);

      do_reset();
      run_string(9'd0, 6'd5, 1'b0, 1'b0, 0, 0);
      run_string(9'd0, 6'd7, 1'b0, 1'b0, 0, 0);
      run_string(9'd3, 6'd63, 1'b0, 1'b0, 0, 0);
      run_string(9'd4, 6'd0, 1'b0, 1'b0, 0, 0);
      chk("t4_seq", seq_seen, 2);
      run_string(9'd4, 6'd1, 1'b0, 1'b0, 0, 0);
      build(9'd4, 6'd2, 1'b0, 1'b0);
      sw[3][15:4] = 12'd1304;
      model_string(20);
      send_string(20, 0);
      wait_drain();
      check_state();
      chk("t4_static", stat_seen, STATIC_EN ? 1 : 0);

      run_string(9'd4, 6'd3, 1'b0, 1'b0, 4, 7);
      run_string(9'd4, 6'd4, 1'b0, 1'b0, 0, 0);
      chk("t5_align", align_seen, m_aligns);

      run_string(9'd4, 6'd5, 1'b0, 1'b0, 0, 0);
      send_word(16'hABCD, 1'b0);
      model_fault();
      repeat (4) @(negedge clk);
      check_state();
      chk("t7_align", align_seen, m_aligns);

      for (int i = 0; i < 30; i++) begin
         int f, s, r, aw, ab;
         r = $urandom_range(0, 9);
         s = (m_ps + 1) % 64;
         f = m_pf;
         if (s == 0 || $urandom_range(0, 3) == 0) f = (m_pf + 1) % 512;
         if (r == 7) s = $urandom_range(0, 63);
         else if (r == 8) f = $urandom_range(0, 511);
         aw = 0;
         ab = 0;
         if (i < 29 && $urandom_range(0, 9) == 0) begin
            aw = $urandom_range(1, 19);
            ab = $urandom_range(0, 15);
         end
         run_string(9'(f), 6'(s), $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0, aw, ab);
      end
      chk("rand_align", align_seen, m_aligns);

      build(9'((m_pf + 1) % 512), 6'((m_ps + 1) % 64), 1'b0, 1'b0);
      model_string(1);
      send_string(1, 5);
      n = 0;
      while (n < 3000) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (bus.err_align) break;
      end
      model_fault();
      chk("timeout_lat", n, TO + SS + 1);
      wait_drain();
      send_word(16'h5A5A, 1'b0);
      repeat (4) @(negedge clk);
      check_state();

      force bus.err_cnt = 16'hFFFF;
      repeat (2) @(negedge clk);
      release bus.err_cnt;
      @(negedge clk);
      chk("sat_pre", bus.err_cnt, 16'hFFFF);
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b1);
      m_aligns++;
      repeat (6) @(negedge clk);
      chk("sat", bus.err_cnt, 16'hFFFF);
      chk("align_total", align_seen, m_aligns);
      chk("unexpected_words", unexp, 0);
      chk("stray_pulses", stray, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
